// File: rtl/prince_cms_pkg.sv
// rtl/prince_cms_pkg.sv - shared constants and types for the masked PRINCE datapath
package prince_cms_pkg;

   localparam int DEF_SHARES  = 3;
   localparam int DEF_NIBBLES = 16;
   localparam int NIBBLE_W    = 4;
   localparam int SLICE_W     = NIBBLE_W * DEF_NIBBLES;

   typedef logic [NIBBLE_W-1:0] nibble_t;

endpackage

// File: rtl/prince_inv_affine_nibble.sv
// rtl/prince_inv_affine_nibble.sv - inverse Sbox output affine map on one 4-bit lane
module prince_inv_affine_nibble
   import prince_cms_pkg::*;
(
   input  nibble_t raw,
   output nibble_t mapped
);

   // Lane bit 0 is the nibble MSB: [o0,o1,o2,o3] -> [o1, o0, o3, o0^o2^o3]
   assign mapped = {raw[2], raw[3], raw[0], raw[3] ^ raw[1] ^ raw[0]};

endmodule

// File: rtl/prince_inv_affine_pipe.sv
// rtl/prince_inv_affine_pipe.sv - two-stage share-wise inverse affine pipeline with flush
module prince_inv_affine_pipe
   import prince_cms_pkg::*;
#(
   parameter int SHARES  = DEF_SHARES,
   parameter int NIBBLES = DEF_NIBBLES
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_valid,
   output logic                            o_ready,
   input  logic [SHARES*NIBBLE_W*NIBBLES-1:0] i_shares,
   input  logic                            i_flush,
   output logic                            o_valid,
   input  logic                            i_ready,
   output logic [SHARES*NIBBLE_W*NIBBLES-1:0] o_shares
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int TOTAL = SHARES * W;

   logic             s1_valid;
   logic             s2_valid;
   logic [TOTAL-1:0] s1_data;
   logic [TOTAL-1:0] s2_data;
   logic [TOTAL-1:0] mapped;
   logic             in_fire;
   logic             s2_load;
   logic             out_fire;

   // S1 can take a beat whenever it is empty or about to drain into S2
   assign o_ready  = !i_flush && (!s2_valid || i_ready || !s1_valid);
   assign in_fire  = i_valid && o_ready;
   assign s2_load  = s1_valid && (!s2_valid || i_ready);
   assign out_fire = s2_valid && i_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else if (i_flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (in_fire) begin
            s1_valid <= 1'b1;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end
         if (s2_load) begin
            s2_valid <= 1'b1;
         end else if (out_fire) begin
            s2_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_data <= '0;
         s2_data <= '0;
      end else begin
         if (in_fire) begin
            s1_data <= i_shares;
         end
         if (s2_load) begin
            s2_data <= mapped;
         end
      end
   end

   // Each lane instance reads and writes only its own share slice
   for (genvar s = 0; s < SHARES; s++) begin : g_share
      for (genvar k = 0; k < NIBBLES; k++) begin : g_nib
         prince_inv_affine_nibble u_nib (
            .raw   (s1_data[s*W + NIBBLE_W*k +: NIBBLE_W]),
            .mapped(mapped[s*W + NIBBLE_W*k +: NIBBLE_W])
         );
      end
   end

   assign o_valid  = s2_valid;
   assign o_shares = s2_data;

endmodule
